cbus_arbiter: RTL
=================

CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 2, giving the number of upstream cache-bus masters (2..8).
REQ-002 The block SHALL have port aclk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port areset, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port ireqs, input, NUM_INPUTS x cbus_req_t, the per-master requests (valid, is_write, size, addr, strobe, data, len).
REQ-005 The block SHALL have port oresps, output, NUM_INPUTS x cbus_resp_t, the per-master responses (ready, last, data).
REQ-006 The block SHALL have port oreq, output, cbus_req_t, the request forwarded to the downstream cache-bus-to-AXI bridge.
REQ-007 The block SHALL have port iresp, input, cbus_resp_t, the response from the downstream bridge.

Function
REQ-008 The block SHALL implement a two-state FSM: IDLE (no grant) and BUSY (one master granted, index held in register `sel`).
REQ-009 In IDLE, oreq SHALL be all-zero (oreq.valid=0) and every oresps[i] SHALL be all-zero.
REQ-010 In IDLE, if any ireqs[i].valid=1, the FSM SHALL move to BUSY on the next edge and load sel with the granted index.
REQ-011 Grant SHALL be round-robin: search starts at (last_grant+1) mod NUM_INPUTS; the first valid index in ascending wrap-around order wins.
REQ-012 last_grant SHALL update to sel on every IDLE->BUSY transition.
REQ-013 Grant latency SHALL be exactly one cycle: request visible in cycle N (block in IDLE) -> oreq.valid=1 in cycle N+1.
REQ-014 In BUSY, oreq SHALL equal ireqs[sel] combinationally, so write data/strobe track the master beat by beat.
REQ-015 In BUSY, oresps[sel] SHALL equal iresp combinationally; every oresps[j], j!=sel, SHALL be all-zero.
REQ-016 In BUSY, the grant SHALL be held regardless of other masters' valid and regardless of ireqs[sel].valid, until the downstream completes.
REQ-017 BUSY->IDLE SHALL occur on the edge where iresp.ready=1 and iresp.last=1; the following cycle SHALL be IDLE with oreq.valid=0.
REQ-018 The forced IDLE cycle of REQ-017 SHALL always occur, even with requests pending, so the downstream never samples a stale request at its own idle boundary.
REQ-019 Arbitration in the IDLE cycle SHALL see the post-completion last_grant, so a master just served has lowest priority.
REQ-020 With a single requester, back-to-back transactions from it SHALL be granted with one IDLE cycle between them.
REQ-021 iresp.ready/last in IDLE SHALL be ignored (no state change, nothing routed).
REQ-022 sel and last_grant SHALL be ceil(log2(NUM_INPUTS)) bits wide; wrap-around SHALL be modulo NUM_INPUTS, including non-power-of-two values.

Reset
REQ-023 While areset=1: FSM=IDLE, sel=0, last_grant=NUM_INPUTS-1, so master 0 has highest priority after reset.
REQ-024 Assertion of areset SHALL take effect immediately, independent of aclk; outputs SHALL become the IDLE values of REQ-009 without waiting for an edge.
REQ-025 Reset mid-transaction SHALL abandon the grant; no partial response SHALL be routed after reset.

Verification
REQ-026 Reset release, ireqs[0].valid=1 (read, len=3, addr=0x1000) in cycle 0 -> oreq.valid=1, addr=0x1000 in cycle 1; four iresp.ready beats appear only on oresps[0]; iresp.last on 4th beat -> IDLE next cycle.
REQ-027 ireqs[0] and ireqs[1] both valid continuously, each len=0 -> grants alternate 0,1,0,1 with exactly one IDLE cycle between grants.
REQ-028 Master 1 granted for a write (len=1); master 0 raises valid mid-burst -> oreq keeps master 1 addr/data; oresps[0].ready stays 0 until master 1's last beat; master 0 granted two cycles after last.
REQ-029 NUM_INPUTS=3, last_grant=2, masters 1 and 2 valid -> master 1 granted (wrap search 0,1,2).
REQ-030 areset asserted asynchronously mid-burst of master 1 -> oreq.valid=0 and all oresps zero before next edge; after release, masters 0 and 1 valid -> master 0 granted first.
REQ-031 iresp.ready=1, last=1 pulsed while IDLE -> no state change, all oresps remain zero.

Source files
------------

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin arbiter that lets NUM_INPUTS cache-bus masters
// share one downstream cache-bus-to-AXI bridge.
//
// Ports
//   aclk    - clock, all state changes on the rising edge
//   areset  - asynchronous active-high reset
//   ireqs   - per-master requests (valid, is_write, size, addr, strobe, data, len)
//   oresps  - per-master responses (ready, last, data); only the granted
//             master sees traffic, all others read zero
//   oreq    - request forwarded to the bridge (zero while no grant)
//   iresp   - response from the bridge
//
// One master owns the bridge from grant until the bridge returns a beat with
// ready and last together. After every completion there is always one cycle
// with no grant, so the bridge never sees a request from a stale owner.

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  cbus_req_t  [NUM_INPUTS-1:0]   ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0]   oresps,
    output cbus_req_t                     oreq,
    input  cbus_resp_t                    iresp
);

    localparam int SEL_W = $clog2(NUM_INPUTS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic [SEL_W-1:0] grant_idx;
    logic             grant_found;

    // Round-robin pick: scan from last_grant+1 upward with wrap-around. The
    // modulo is done on integers so non-power-of-two counts wrap correctly.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] cand;
        grant_idx   = '0;
        grant_found = 1'b0;
        idx         = 0;
        cand        = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            idx  = (int'(last_grant_q) + k) % NUM_INPUTS;
            cand = SEL_W'(idx);
            if (!grant_found && ireqs[cand].valid) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state logic. The grant is held in BUSY no matter what any master
    // does; only the bridge's final beat releases it.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d      = BUSY;
                    sel_d        = grant_idx;
                    last_grant_d = grant_idx;
                end
            end
            BUSY: begin
                if (iresp.ready && iresp.last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to the top index so master 0 wins first after reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_grant_q <= SEL_W'(NUM_INPUTS - 1);
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Routing is combinational from the registered grant so write data and
    // strobes follow the owning master beat by beat. Because reset clears
    // state_q asynchronously, the outputs drop to zero as soon as reset rises.
    always_comb begin
        oreq   = '0;
        oresps = '0;
        if (state_q == BUSY) begin
            oreq          = ireqs[sel_q];
            oresps[sel_q] = iresp;
        end
    end

endmodule
